// File: rtl/perf_meas_chan_if.sv
// Monitored handshake bundle plus the published snapshot outputs of perf_meas_chan.
// The monitor side (slave) only observes valid/ready and never drives them.
interface perf_meas_chan_if #(
    parameter int NCH = 4,
    parameter int CW  = 32,
    parameter int WW  = 24
);
    logic [NCH-1:0]    valid;
    logic [NCH-1:0]    ready;
    logic [NCH*CW-1:0] xfer_count;
    logic [NCH*CW-1:0] stall_count;
    logic [WW-1:0]     window_len;
    logic              report;

    modport master (
        output valid, ready,
        input  xfer_count, stall_count, window_len, report
    );

    modport slave (
        input  valid, ready,
        output xfer_count, stall_count, window_len, report
    );
endinterface

// File: rtl/perf_meas_chan.sv
// Multi-channel transfer/stall meter with a self-tuning power-of-two measurement window.
// Define SB_PERF_DISPLAY_EN to print one line per channel on every report pulse.
module perf_meas_chan #(
    parameter int NCH         = 4,
    parameter int CW          = 32,
    parameter int WW          = 24,
    parameter int INIT_WINDOW = 1024,
    parameter int MIN_WINDOW  = 16,
    parameter int MAX_WINDOW  = 1048576,
    parameter int MIN_EVENTS  = 64,
    parameter int FACTOR_LOG2 = 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             i_en,
    input  logic             i_clear,
    perf_meas_chan_if.slave  bus
);
    localparam int TW = CW + $clog2(NCH) + 1;
    localparam int EW = (TW > 32) ? TW : 32;
    localparam int UW = WW + FACTOR_LOG2;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [WW-1:0] INIT_W  = WW'(INIT_WINDOW);
    localparam logic [WW-1:0] MIN_W   = WW'(MIN_WINDOW);
    localparam logic [UW-1:0] MAX_W   = UW'(MAX_WINDOW);
    localparam logic [EW-1:0] MIN_EV  = EW'(MIN_EVENTS);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t             r_state, w_state_next;
    logic [WW-1:0]      r_cyc;
    logic [WW-1:0]      r_window_cur;
    logic [WW-1:0]      w_window_next;
    logic [WW-1:0]      w_cyc_cur;
    logic [WW-1:0]      w_down;
    logic [UW-1:0]      w_up;
    logic [TW-1:0]      w_total;
    logic               w_count;
    logic               w_last;
    logic               w_restart;
    logic [NCH-1:0]     w_sat_ch;
    logic [NCH*CW-1:0]  w_xfer_flat;
    logic [NCH*CW-1:0]  w_stall_flat;
    logic [NCH*CW-1:0]  r_xfer_snap;
    logic [NCH*CW-1:0]  r_stall_snap;
    logic [WW-1:0]      r_window_len;
    logic               r_report;

    // An enabled IDLE cycle is already the first counted cycle of a window.
    assign w_count   = i_en & ~i_clear;
    assign w_cyc_cur = (r_state == ST_RUN) ? r_cyc : '0;
    assign w_last    = w_count && (w_cyc_cur == r_window_cur - WW'(1));
    assign w_restart = ~w_count | w_last;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_clear) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (i_en)  w_state_next = ST_RUN;
                ST_RUN:  if (!i_en) w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CW-1:0] r_xfer;
            logic [CW-1:0] r_stall;
            logic          r_sat;
            logic          w_xfer_inc;
            logic          w_stall_inc;
            logic          w_xfer_full;
            logic          w_stall_full;

            assign w_xfer_inc   = bus.valid[gi] & bus.ready[gi];
            assign w_stall_inc  = bus.valid[gi] & ~bus.ready[gi];
            assign w_xfer_full  = (r_xfer == CNT_MAX);
            assign w_stall_full = (r_stall == CNT_MAX);
            assign w_xfer_flat[gi*CW +: CW]  = w_xfer_full  ? CNT_MAX : r_xfer  + CW'(w_xfer_inc);
            assign w_stall_flat[gi*CW +: CW] = w_stall_full ? CNT_MAX : r_stall + CW'(w_stall_inc);
            assign w_sat_ch[gi] = r_sat | (w_xfer_full & w_xfer_inc) | (w_stall_full & w_stall_inc);

            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    r_xfer  <= '0;
                    r_stall <= '0;
                    r_sat   <= 1'b0;
                end else if (w_restart) begin
                    r_xfer  <= '0;
                    r_stall <= '0;
                    r_sat   <= 1'b0;
                end else begin
                    r_xfer  <= w_xfer_flat[gi*CW +: CW];
                    r_stall <= w_stall_flat[gi*CW +: CW];
                    r_sat   <= w_sat_ch[gi];
                end
            end

`ifdef SB_PERF_DISPLAY_EN
            logic r_snap_sat;
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    r_snap_sat <= 1'b0;
                end else if (w_last) begin
                    r_snap_sat <= w_sat_ch[gi];
                end
            end
            always_ff @(posedge clk) begin
                if (r_report) begin
                    $display("ch%0d: xfer=%0d stall=%0d window=%0d%s", gi,
                             r_xfer_snap[gi*CW +: CW], r_stall_snap[gi*CW +: CW],
                             r_window_len, r_snap_sat ? " (sat)" : "");
                end
            end
`else
`endif
        end
    endgenerate

    always_comb begin
        w_total = '0;
        for (int i = 0; i < NCH; i++) begin
            w_total = w_total + TW'(w_xfer_flat[i*CW +: CW]);
        end
    end

    // Widened up-shift so the clamp against MAX_WINDOW sees any overflow.
    assign w_down = r_window_cur >> FACTOR_LOG2;
    assign w_up   = UW'(r_window_cur) << FACTOR_LOG2;

    always_comb begin
        w_window_next = r_window_cur;
        if (|w_sat_ch) begin
            w_window_next = (w_down < MIN_W) ? MIN_W : w_down;
        end else if (EW'(w_total) < MIN_EV) begin
            w_window_next = (w_up > MAX_W) ? WW'(MAX_W) : WW'(w_up);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cyc        <= '0;
            r_window_cur <= INIT_W;
        end else begin
            r_cyc <= w_restart ? '0 : w_cyc_cur + WW'(1);
            if (i_clear) begin
                r_window_cur <= INIT_W;
            end else if (w_last) begin
                r_window_cur <= w_window_next;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_xfer_snap  <= '0;
            r_stall_snap <= '0;
            r_window_len <= '0;
            r_report     <= 1'b0;
        end else begin
            r_report <= w_last;
            if (w_last) begin
                r_xfer_snap  <= w_xfer_flat;
                r_stall_snap <= w_stall_flat;
                r_window_len <= r_window_cur;
            end
        end
    end

    assign bus.xfer_count  = r_xfer_snap;
    assign bus.stall_count = r_stall_snap;
    assign bus.window_len  = r_window_len;
    assign bus.report      = r_report;
endmodule
